// File: rtl/platform_nios_jtag_ocimem_arbiter_if.sv
// CPU debug-slave and OCI RAM port bundle shared by the arbiter and its environment.
// slave = arbiter view; master = CPU requester plus RAM responder.
interface platform_nios_jtag_ocimem_arbiter_if #(
    parameter int AW = 8
);
    logic [AW-1:0] cpu_address;
    logic          cpu_read;
    logic          cpu_write;
    logic [31:0]   cpu_writedata;
    logic [3:0]    cpu_byteenable;
    logic          cpu_waitrequest;
    logic [31:0]   cpu_readdata;
    logic          cpu_readdatavalid;

    logic [AW-1:0] ram_address;
    logic          ram_wren;
    logic [3:0]    ram_byteenable;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    modport slave (
        input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable, ram_rdata,
        output cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
               ram_address, ram_wren, ram_byteenable, ram_wdata
    );

    modport master (
        output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable, ram_rdata,
        input  cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
               ram_address, ram_wren, ram_byteenable, ram_wdata
    );
endinterface

// File: rtl/platform_nios_jtag_ocimem_arbiter.sv
// Shares the OCI RAM port between JTAG monitor accesses and the CPU debug slave.
// JTAG write ready 2 cycles after strobe, read 3; CPU waitrequest only while JTAG is forced through.
module platform_nios_jtag_ocimem_arbiter #(
    parameter int AW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo_i,
    input  logic        take_action_ocimem_a_i,
    input  logic        take_no_action_ocimem_a_i,
    input  logic        take_action_ocimem_b_i,
    platform_nios_jtag_ocimem_arbiter_if.slave bus,
    output logic [31:0] MonDReg_o,
    output logic        monitor_ready_o,
    output logic        monitor_error_o,
    output logic        jtag_busy_o
);
    localparam int SW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, JREQ, JRD, DONE} state_e;

    state_e        state_q;
    logic [AW-1:0] mon_addr_q;
    logic [AW-1:0] mon_addr_d;
    logic [31:0]   wdata_q;
    logic [31:0]   mon_dreg_q;
    logic          is_wr_q;
    logic          ready_q;
    logic          error_q;
    logic          busy_q;
    logic          rdv_q;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;

    logic cpu_req;
    logic jtag_grant;
    logic cpu_grant;
    logic any_take;
    logic start_rd;
    logic start_wr;
    logic unused_jdo;

    assign unused_jdo = ^{jdo_i[37:36], jdo_i[1:0]};

    always_comb begin
        cpu_req    = bus.cpu_read | bus.cpu_write;
        // Gating on reset_n keeps a pending JTAG write off the RAM during the reset cycle.
        jtag_grant = reset_n && (state_q == JREQ) && (!cpu_req || (starve_q == SW'(MAX_WAIT)));
        cpu_grant  = reset_n && cpu_req && !jtag_grant;
        any_take   = take_action_ocimem_a_i | take_action_ocimem_b_i | take_no_action_ocimem_a_i;
        start_wr   = !take_action_ocimem_a_i && take_action_ocimem_b_i;
        start_rd   = take_action_ocimem_a_i ? jdo_i[35]
                                            : (!take_action_ocimem_b_i && take_no_action_ocimem_a_i);
        mon_addr_d = mon_addr_q + 1'b1;

        starve_d = starve_q;
        if (jtag_grant) begin
            starve_d = '0;
        end else if ((state_q == JREQ) && (starve_q != SW'(MAX_WAIT))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        bus.ram_address    = bus.cpu_address;
        bus.ram_wdata      = bus.cpu_writedata;
        bus.ram_byteenable = bus.cpu_byteenable;
        bus.ram_wren       = cpu_grant & bus.cpu_write;
        if (jtag_grant) begin
            bus.ram_address    = mon_addr_q;
            bus.ram_wdata      = wdata_q;
            bus.ram_byteenable = 4'hF;
            bus.ram_wren       = is_wr_q;
        end
        bus.cpu_waitrequest   = cpu_req & ~cpu_grant;
        bus.cpu_readdata      = bus.ram_rdata;
        bus.cpu_readdatavalid = rdv_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mon_addr_q <= '0;
            wdata_q    <= '0;
            mon_dreg_q <= '0;
            is_wr_q    <= 1'b0;
            ready_q    <= 1'b1;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
            rdv_q      <= 1'b0;
            starve_q   <= '0;
        end else begin
            rdv_q    <= cpu_grant & bus.cpu_read & ~bus.cpu_write;
            starve_q <= starve_d;
            if ((state_q != IDLE) && any_take) begin
                error_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (take_action_ocimem_a_i) begin
                        mon_addr_q <= jdo_i[AW+1:2];
                        error_q    <= 1'b0;
                    end
                    if (start_rd || start_wr) begin
                        is_wr_q <= start_wr;
                        wdata_q <= jdo_i[34:3];
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= JREQ;
                    end
                end
                JREQ: begin
                    if (jtag_grant) begin
                        if (is_wr_q) begin
                            mon_addr_q <= mon_addr_d;
                            ready_q    <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= DONE;
                        end else begin
                            state_q <= JRD;
                        end
                    end
                end
                JRD: begin
                    mon_dreg_q <= bus.ram_rdata;
                    mon_addr_q <= mon_addr_d;
                    ready_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MonDReg_o       = mon_dreg_q;
    assign monitor_ready_o = ready_q;
    assign monitor_error_o = error_q;
    assign jtag_busy_o     = busy_q;
endmodule

// File: tb/tb_platform_nios_jtag_ocimem_arbiter.sv
// Scoreboarded bench: JTAG and CPU expectations come from a word-array model of the OCI RAM.
`timescale 1ns/1ps
module tb_platform_nios_jtag_ocimem_arbiter;
    localparam int AW = 8;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
        int          issue;
        int          lat;
    } jexp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_a, take_b, take_na;
    logic [31:0] mondreg;
    logic        mready, merror, jbusy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] wmerge;
    logic [7:0]  mon_addr_m;
    jexp_t       jq[$];
    logic [31:0] cq[$];
    jexp_t       jx;
    logic [31:0] ce;
    bit          rst_drop = 0;
    logic        prev_ready = 1'b1;

    platform_nios_jtag_ocimem_arbiter_if #(.AW(AW)) ifc ();

    platform_nios_jtag_ocimem_arbiter #(.AW(AW), .MAX_WAIT(4)) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .jdo_i                     (jdo),
        .take_action_ocimem_a_i    (take_a),
        .take_no_action_ocimem_a_i (take_na),
        .take_action_ocimem_b_i    (take_b),
        .bus                       (ifc),
        .MonDReg_o                 (mondreg),
        .monitor_ready_o           (mready),
        .monitor_error_o           (merror),
        .jtag_busy_o               (jbusy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM with one-cycle registered read returning pre-write contents.
    always @(posedge clk) begin
        ifc.ram_rdata <= mem[ifc.ram_address];
        if (ifc.ram_wren === 1'b1) begin
            wmerge = mem[ifc.ram_address];
            for (int b = 0; b < 4; b++)
                if (ifc.ram_byteenable[b]) wmerge[8*b +: 8] = ifc.ram_wdata[8*b +: 8];
            mem[ifc.ram_address] = wmerge;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: event missing or unexpected", nm);
    endtask

    // Monitor: pops expectations whenever the DUT presents read data or completes a JTAG access.
    initial forever begin
        @(negedge clk);
        if (ifc.cpu_readdatavalid === 1'b1) begin
            if (cq.size() == 0) fail("cpu_rdv_unexpected");
            else begin
                ce = cq.pop_front();
                chk("cpu_readdata", ifc.cpu_readdata, ce);
            end
        end
        if (mready === 1'b1 && prev_ready === 1'b0) begin
            if (rst_drop) rst_drop = 0;
            else if (jq.size() == 0) fail("jtag_ready_unexpected");
            else begin
                jx = jq.pop_front();
                if (jx.is_rd) chk("MonDReg", mondreg, jx.data);
                if (jx.lat > 0) chk("jtag_latency", cyc - jx.issue, jx.lat);
                chk("jtag_busy_clear", {31'd0, jbusy}, 32'd0);
            end
        end
        prev_ready = mready;
    end

    // kind: 0 = ocimem_a, 1 = ocimem_b (write), 2 = no_action_ocimem_a (read)
    task automatic jtag_op(input int kind, input logic [7:0] addr, input logic rd,
                           input logic [31:0] data, input int lat);
        jexp_t x;
        bit got;
        jdo = {6'($urandom), $urandom};
        x.issue = cyc;
        x.lat   = lat;
        case (kind)
            0: begin
                take_a = 1; jdo[AW+1:2] = addr; jdo[35] = rd; mon_addr_m = addr;
                if (rd) begin
                    x.is_rd = 1; x.data = ref_mem[addr]; jq.push_back(x); mon_addr_m++;
                end
            end
            1: begin
                take_b = 1; jdo[34:3] = data; ref_mem[mon_addr_m] = data;
                x.is_rd = 0; x.data = 0; jq.push_back(x); mon_addr_m++;
            end
            default: begin
                take_na = 1; x.is_rd = 1; x.data = ref_mem[mon_addr_m]; jq.push_back(x); mon_addr_m++;
            end
        endcase
        @(posedge clk); #1;
        take_a = 0; take_b = 0; take_na = 0;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mready === 1'b1) begin got = 1; break; end
        end
        if (!got) fail("jtag_ready_timeout");
        @(posedge clk); #1;
    endtask

    task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [31:0] wd, input logic [3:0] be);
        bit done;
        done = 0;
        ifc.cpu_read = rd; ifc.cpu_write = wr; ifc.cpu_address = addr;
        ifc.cpu_writedata = wd; ifc.cpu_byteenable = be;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (ifc.cpu_waitrequest === 1'b0) begin
                done = 1;
                if (wr) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
                end else if (rd) begin
                    cq.push_back(ref_mem[addr]);
                end
            end
            @(posedge clk); #1;
        end
        if (!done) fail("cpu_accept_timeout");
        ifc.cpu_read = 0; ifc.cpu_write = 0;
    endtask

    // CPU reads every cycle while a JTAG write waits; optional overrun strobe while in JREQ.
    task automatic starve_round(input logic [31:0] wd, input bit ovr);
        int stalls, stall_at, wrens;
        logic [7:0] a, jaddr;
        jexp_t x;
        stalls = 0; stall_at = -1; wrens = 0; a = 8'h40; jaddr = mon_addr_m;
        for (int k = 0; k < 12; k++) begin
            ifc.cpu_read = 1; ifc.cpu_write = 0; ifc.cpu_address = a;
            take_b = (k == 0); take_na = ovr && (k == 2);
            jdo = {3'b000, wd, 3'b000};
            if (k == 0) begin
                ref_mem[mon_addr_m] = wd; mon_addr_m++;
                x.is_rd = 0; x.data = 0; x.issue = cyc; x.lat = 0; jq.push_back(x);
            end
            @(negedge clk);
            if (ifc.cpu_waitrequest === 1'b1) begin stalls++; stall_at = k; end
            else begin cq.push_back(ref_mem[a]); a++; end
            if (ifc.ram_wren === 1'b1) begin
                wrens++;
                chk("starve_jtag_addr", {24'd0, ifc.ram_address}, {24'd0, jaddr});
                chk("starve_jtag_wdata", ifc.ram_wdata, wd);
            end
            @(posedge clk); #1;
        end
        take_b = 0; take_na = 0; ifc.cpu_read = 0;
        chk("starve_stall_count", stalls, 1);
        chk("starve_stall_cycle", stall_at, 5);
        chk("starve_wren_count", wrens, 1);
        chk("monitor_error", {31'd0, merror}, {31'd0, ovr});
    endtask

    initial begin
        int wrens;
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin mem[i] = 0; ref_mem[i] = 0; end
        reset_n = 0; jdo = '0; take_a = 0; take_b = 0; take_na = 0;
        ifc.cpu_read = 0; ifc.cpu_write = 0; ifc.cpu_address = '0;
        ifc.cpu_writedata = '0; ifc.cpu_byteenable = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, mready}, 32'd1);
        chk("rst_error", {31'd0, merror}, 32'd0);
        chk("rst_busy", {31'd0, jbusy}, 32'd0);
        chk("rst_mondreg", mondreg, 32'd0);
        chk("rst_rdv", {31'd0, ifc.cpu_readdatavalid}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1;
        mon_addr_m = 8'h00;

        // Write at 0x10 then 0x11, read both back through ocimem_a and no_action.
        jtag_op(0, 8'h10, 0, 0, 0);
        jtag_op(1, 8'h00, 0, 32'hDEADBEEF, 2);
        chk("t1_ram10", mem[8'h10], 32'hDEADBEEF);
        jtag_op(1, 8'h00, 0, 32'hCAFEF00D, 2);
        chk("t1_ram11", mem[8'h11], 32'hCAFEF00D);
        jtag_op(0, 8'h10, 1, 0, 3);
        chk("t2_mondreg", mondreg, 32'hDEADBEEF);
        jtag_op(2, 8'h00, 0, 0, 3);

        // Address wrap at the top of the RAM.
        jtag_op(0, 8'hFF, 0, 0, 0);
        jtag_op(1, 8'h00, 0, 32'h11111111, 2);
        jtag_op(1, 8'h00, 0, 32'h22222222, 2);
        chk("wrap_ff", mem[8'hFF], ref_mem[8'hFF]);
        chk("wrap_00", mem[8'h00], ref_mem[8'h00]);

        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    logic r, w;
                    r = 1'($urandom); w = 1'($urandom);
                    if (!r && !w) r = 1;
                    cpu_access(r, w, 8'h40 + 8'($urandom_range(0, 127)), $urandom, 4'($urandom));
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int i = 0; i < 25; i++)
                    jtag_op($urandom_range(0, 2), 8'($urandom_range(0, 31)), 1'($urandom), $urandom, 0);
            end
        join

        jtag_op(0, 8'h20, 0, 0, 0);
        starve_round(32'hA5A5_0001, 0);
        starve_round(32'hA5A5_0002, 1);
        jtag_op(0, 8'h30, 0, 0, 0);
        chk("error_cleared", {31'd0, merror}, 32'd0);

        jtag_op(0, 8'h12, 0, 0, 0);
        jtag_op(1, 8'h00, 0, 32'h600DF00D, 2);
        jtag_op(0, 8'h12, 1, 0, 3);

        // One-cycle reset while a JTAG write is starved in JREQ.
        rst_drop = 1; wrens = 0; a = 8'h40;
        for (int k = 0; k < 8; k++) begin
            ifc.cpu_read = 1; ifc.cpu_address = a;
            take_b = (k == 0); jdo = {3'b000, 32'hBAD0BAD0, 3'b000};
            reset_n = (k != 2);
            @(negedge clk);
            if (ifc.cpu_waitrequest === 1'b0) begin cq.push_back(ref_mem[a]); a++; end
            if (ifc.ram_wren === 1'b1) wrens++;
            @(posedge clk); #1;
        end
        ifc.cpu_read = 0; take_b = 0;
        mon_addr_m = 8'h00;
        chk("rstmid_wren_count", wrens, 0);
        chk("rstmid_ready", {31'd0, mready}, 32'd1);
        chk("rstmid_mondreg", mondreg, 32'd0);
        chk("rstmid_busy", {31'd0, jbusy}, 32'd0);
        chk("rstmid_error", {31'd0, merror}, 32'd0);
        jtag_op(1, 8'h00, 0, 32'h0BADCAFE, 2);
        chk("rstmid_addr0", mem[8'h00], 32'h0BADCAFE);

        repeat (5) @(posedge clk);
        chk("cpu_queue_drained", cq.size(), 0);
        chk("jtag_queue_drained", jq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
